mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped serial transmitter on the CPU data bus, alongside the RAM, LED register and switch port. The CPU writes bytes to a data address; the block buffers them in a small FIFO and shifts them out as 8N1 frames on a single output pin. A status register at a second address reports FIFO and transmitter state, so software can poll before writing. The top-level read mux selects this block's read_data when rd_hit is asserted.

Parameters:
FIFO_DEPTH, 4, number of buffered bytes; power of two, at least 2
CLKS_PER_BIT, 16, clk cycles per serial bit; at least 2
TXDATA_ADDR, 9'h180, write address that pushes a byte
STATUS_ADDR, 9'h181, read address of the status word

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mem_cmd  input  2  bus command: 2'b10 = read, 2'b11 = write, other values = none
mem_addr  input  9  bus address
write_data  input  16  bus write data; only bits [7:0] are used
read_data  output  16  status word; combinational
rd_hit  output  1  high when (mem_cmd==2'b10) and (mem_addr==STATUS_ADDR); combinational
tx  output  1  serial line; registered; idle level is 1

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - tx=1 and the FSM is in IDLE.
  - The FIFO is empty, the overflow flag is 0 and all counters are 0.
  - Reset mid-frame aborts the frame at once. No partial byte is held afterwards.
- Push: a cycle with mem_cmd==2'b11 and mem_addr==TXDATA_ADDR is sampled at the rising edge.
  - write_data[7:0] enters the FIFO tail if the FIFO is not full, or if a pop happens on the same edge.
  - Otherwise the byte is dropped and the sticky overflow flag is set.
- Status word: read_data = {12'b0, overflow, busy, full, empty}.
  - busy = (state != IDLE).
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - read_data is valid every cycle regardless of rd_hit.
- Overflow is cleared on the rising edge of a cycle where rd_hit=1. That cycle still returns overflow=1 combinationally.
- Reads at TXDATA_ADDR return nothing: rd_hit=0 for them.
- Writes at STATUS_ADDR and all other addresses are ignored.
- FIFO count occupies log2(FIFO_DEPTH)+1 bits. Head and tail pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START. tx=0 from that edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx = bit0.
  - DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles. A 3-bit bit index counts 0..7. After bit7, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle cycle). Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: a write sampled at edge E0 with an empty FIFO in IDLE makes tx fall at edge E1. busy=1 and empty=1 after E1.
- Pushes during a frame never disturb the byte being shifted.

Test Plan:
- Reset, then write 0x0155 to 0x180 (CLKS_PER_BIT=4) -> tx falls 1 cycle later. Per 4-cycle slot, tx = 0,1,0,1,0,1,0,1,0,1. The upper byte is ignored. Idle after 40 cycles; status = 16'h0001.
- Write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back with tx low (start bit) at cycle 40 of the first frame. The line carries 0xA3 then 0x0F, LSB first.
- With FIFO_DEPTH=4: six writes 0x01..0x06 in consecutive cycles -> 0x01 is popped after E1, so 0x02..0x05 fill the FIFO and 0x06 is dropped. Status = 16'h000E (overflow, busy, full). Transmitted bytes are 0x01..0x05.
- Read 0x181 after the overflow -> rd_hit=1 and read_data bit3=1 that cycle. The next status read returns bit3=0.
- Assert reset 13 cycles into a frame with 2 bytes queued -> tx=1 immediately, status = 16'h0001 after release, and no further frames are sent.
- Read 0x180, read 0x140, and write 0x181 -> rd_hit=0 for all three, FIFO unchanged, tx stays 1.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter.
// A bus write to TXDATA_ADDR queues a byte in a small FIFO, and the queued bytes are
// shifted out LSB first on tx. A read at STATUS_ADDR returns the overflow, busy, full
// and empty flags.
module mmio_uart_tx #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [8:0]  TXDATA_ADDR  = 9'h180,
    parameter logic [8:0]  STATUS_ADDR  = 9'h181
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        rd_hit,
    output logic        tx
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0]  FullCnt  = CntW'(FIFO_DEPTH);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t           state;
    logic [BaudW-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] head;
    logic [PtrW-1:0] tail;
    logic [CntW-1:0] count;
    logic            overflow;

    logic full, empty, busy, baud_last;
    logic push_req, push_ok, pop;

    // Only the low byte of the bus data is transmitted.
    logic unused_wdata;
    assign unused_wdata = ^write_data[15:8];

    // Bus decode, status flags and the pop/push handshake.
    always_comb begin
        full      = (count == FullCnt);
        empty     = (count == '0);
        busy      = (state != StIdle);
        baud_last = (baud_cnt == BaudLast);
        rd_hit    = (mem_cmd == 2'b10) && (mem_addr == STATUS_ADDR);
        read_data = {12'b0, overflow, busy, full, empty};
        pop       = !empty && ((state == StIdle) || ((state == StStop) && baud_last));
        push_req  = (mem_cmd == 2'b11) && (mem_addr == TXDATA_ADDR);
        // A full FIFO still accepts a byte when the head leaves on the same edge.
        push_ok   = push_req && (!full || pop);
    end

    // FIFO storage; the head is read before the tail write lands when both share a slot.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[tail] <= write_data[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) tail <= tail + PtrW'(1);
            if (pop)     head <= head + PtrW'(1);
            if (push_ok && !pop) begin
                count <= count + CntW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CntW'(1);
            end
            if (rd_hit) begin
                overflow <= 1'b0;
            end else if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmit FSM with registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= fifo_mem[head];
                        state     <= StStart;
                        tx        <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= StData;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= fifo_mem[head];
                            state     <= StStart;
                            tx        <= 1'b0;
                        end else begin
                            state <= StIdle;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BaudW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with 4 clocks per bit and a 4-entry FIFO.
module tb_mmio_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_hit;
    logic        tx;

    int checks   = 0;
    int failures = 0;

    mmio_uart_tx #(
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(CPB),
        .TXDATA_ADDR (9'h180),
        .STATUS_ADDR (9'h181)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .write_data(write_data),
        .read_data (read_data),
        .rd_hit    (rd_hit),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic        exp_hit;
        logic [15:0] exp_rd;
        logic        exp_tx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock, leaving the inputs settled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [15:0] d);
        mem_cmd    = 2'b11;
        mem_addr   = 9'h180;
        write_data = d;
        tick();
        mem_cmd = 2'b00;
    endtask

    // Checks tx for one frame, one sample per clock; the caller sits just past the
    // edge that produced sample 'first'.
    task automatic expect_frame(input logic [7:0] b, input int first, input string name);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = first; i < 10 * CPB; i++) begin
            check(name, {15'b0, tx}, {15'b0, bits[i / CPB]});
            tick();
        end
    endtask

    task automatic status_read(input string name, input logic [15:0] exp);
        mem_cmd  = 2'b10;
        mem_addr = 9'h181;
        #3;
        check({name, "_hit"}, {15'b0, rd_hit}, 16'h0001);
        check(name, read_data, exp);
        tick();
        mem_cmd = 2'b00;
    endtask

    initial begin
        vecs[0] = '{"rd_txdata", 2'b10, 9'h180, 16'h0000, 1'b0, 16'h0001, 1'b1};
        vecs[1] = '{"rd_other",  2'b10, 9'h140, 16'h0000, 1'b0, 16'h0001, 1'b1};
        vecs[2] = '{"wr_status", 2'b11, 9'h181, 16'h00AA, 1'b0, 16'h0001, 1'b1};
        vecs[3] = '{"after_wr",  2'b10, 9'h181, 16'h0000, 1'b1, 16'h0001, 1'b1};
        vecs[4] = '{"cmd_none",  2'b00, 9'h181, 16'h0000, 1'b0, 16'h0001, 1'b1};
        vecs[5] = '{"cmd_01",    2'b01, 9'h181, 16'h0000, 1'b0, 16'h0001, 1'b1};
        vecs[6] = '{"wr_other",  2'b11, 9'h17F, 16'h0055, 1'b0, 16'h0001, 1'b1};
        vecs[7] = '{"final_rd",  2'b10, 9'h181, 16'h0000, 1'b1, 16'h0001, 1'b1};

        reset      = 1'b1;
        mem_cmd    = 2'b00;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
        #12;
        check("reset_tx", {15'b0, tx}, 16'h0001);
        check("reset_status", read_data, 16'h0001);
        #10;
        reset = 1'b0;
        tick();

        // Accesses that must not touch the FIFO or the line.
        for (int i = 0; i < 8; i++) begin
            mem_cmd    = vecs[i].cmd;
            mem_addr   = vecs[i].addr;
            write_data = vecs[i].wdata;
            #3;
            check({vecs[i].name, "_hit"}, {15'b0, rd_hit}, {15'b0, vecs[i].exp_hit});
            check({vecs[i].name, "_rd"}, read_data, vecs[i].exp_rd);
            check({vecs[i].name, "_tx"}, {15'b0, tx}, {15'b0, vecs[i].exp_tx});
            tick();
        end
        mem_cmd = 2'b00;
        check("idle_after_table_tx", {15'b0, tx}, 16'h0001);

        // Single byte: upper byte ignored, one-cycle latency.
        write_byte(16'h0155);
        check("lat_e0_tx", {15'b0, tx}, 16'h0001);
        check("lat_e0_status", read_data, 16'h0000);
        tick();
        check("lat_e1_status", read_data, 16'h0005);
        expect_frame(8'h55, 0, "frame_55");
        check("idle_after_55", read_data, 16'h0001);

        // Back-to-back frames.
        mem_cmd    = 2'b11;
        mem_addr   = 9'h180;
        write_data = 16'h00A3;
        tick();
        write_data = 16'h000F;
        tick();
        mem_cmd = 2'b00;
        expect_frame(8'hA3, 0, "frame_a3");
        expect_frame(8'h0F, 0, "frame_0f");
        check("idle_after_b2b", read_data, 16'h0001);

        // Overflow: six writes, 0x01 popped early, 0x06 dropped.
        mem_cmd  = 2'b11;
        mem_addr = 9'h180;
        for (int i = 1; i <= 6; i++) begin
            write_data = 16'(i);
            tick();
        end
        mem_cmd = 2'b00;
        check("ovf_status", read_data, 16'h000E);
        expect_frame(8'h01, 4, "frame_01");
        for (int i = 2; i <= 5; i++) begin
            expect_frame(8'(i), 0, "frame_q");
        end
        check("idle_after_ovf_tx", {15'b0, tx}, 16'h0001);
        status_read("ovf_read1", 16'h0009);
        status_read("ovf_read2", 16'h0001);

        // Reset in the middle of a frame with two bytes queued.
        mem_cmd  = 2'b11;
        mem_addr = 9'h180;
        for (int i = 0; i < 3; i++) begin
            write_data = 16'h00F0 + 16'(i);
            tick();
        end
        mem_cmd = 2'b00;
        for (int i = 0; i < 11; i++) tick();
        check("mid_frame_busy", read_data, 16'h0004);
        #2;
        reset = 1'b1;
        #1;
        check("abort_tx", {15'b0, tx}, 16'h0001);
        check("abort_status", read_data, 16'h0001);
        #10;
        reset = 1'b0;
        tick();
        check("post_reset_status", read_data, 16'h0001);
        begin
            int low_cycles;
            low_cycles = 0;
            for (int i = 0; i < 50; i++) begin
                if (tx !== 1'b1) low_cycles++;
                tick();
            end
            check("no_frames_after_reset", 16'(low_cycles), 16'h0000);
        end
        check("final_status", read_data, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
